// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: FSM states,
// configuration register addresses and the interrupt id width.
package intc_pkg;

  // Width of every interrupt id carried between blocks
  localparam int ID_W = 5;

  // Request handshake states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Configuration register map
  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_TCMP    = 2'd2;
  localparam logic [1:0] ADDR_TCNT    = 2'd3;

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag.
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]    req,
  output logic            vld,
  output logic [ID_W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    vld = |req;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-detected sources feed a pending register,
// masked by enable, and the lowest eligible id is handed to the core
// through an IDLE -> REQ -> SERVICE handshake (no nesting).
// Optional build macro INTC_TIMER_EN adds a 32-bit free-running timer
// whose compare match becomes internal source id NUM_SRC.
module intr_ctrl
  import intc_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               interrupt,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               irq_done
);

`ifdef INTC_TIMER_EN
  localparam int TOT = NUM_SRC + 1;
`else
  localparam int TOT = NUM_SRC;
`endif

  state_t          state;
  logic [TOT-1:0]  raw;
  logic [TOT-1:0]  raw_p1;
  logic [TOT-1:0]  rise;
  logic [TOT-1:0]  enable;
  logic [TOT-1:0]  pending;
  logic [TOT-1:0]  eligible;
  logic [TOT-1:0]  sel;
  logic [TOT-1:0]  ack_clr;
  logic [TOT-1:0]  cfg_clr;
  logic            ack_fire;
  logic            id_en;
  logic            win_vld;
  logic [ID_W-1:0] win_id;
  logic            unused_wdata;

  // Upper write-data bits have no register behind them
  assign unused_wdata = ^cfg_wdata;

`ifdef INTC_TIMER_EN
  logic [31:0] tcnt;
  logic [31:0] tcmp;
  logic        tmatch;

  assign tmatch = (tcnt == tcmp);
  assign raw    = {tmatch, src};

  // Free-running count with software override; compare register
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt <= '0;
      tcmp <= 32'hFFFF_FFFF;
    end else begin
      if (cfg_we && cfg_addr == ADDR_TCNT) tcnt <= cfg_wdata;
      else                                 tcnt <= tcnt + 32'd1;
      if (cfg_we && cfg_addr == ADDR_TCMP) tcmp <= cfg_wdata;
    end
  end
`else
  assign raw = src;
`endif

  // Edge history: one cycle of each request line
  always_ff @(posedge clk) begin
    if (reset) raw_p1 <= '0;
    else       raw_p1 <= raw;
  end

  assign rise     = raw & ~raw_p1;
  assign ack_fire = (state == REQ) && irq_ack;
  assign cfg_clr  = (cfg_we && cfg_addr == ADDR_PENDING) ? cfg_wdata[TOT-1:0] : '0;

  // One-hot select of the id currently held by the FSM
  always_comb begin
    sel = '0;
    for (int i = 0; i < TOT; i++) begin
      sel[i] = (irq_id == ID_W'(i));
    end
  end

  assign ack_clr = ack_fire ? sel : '0;
  assign id_en   = |(enable & sel);

  // Pending: clears from ack or write-1-to-clear, a new edge always wins
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~(cfg_clr | ack_clr)) | rise;
  end

  // Enable mask register
  always_ff @(posedge clk) begin
    if (reset)                                  enable <= '0;
    else if (cfg_we && cfg_addr == ADDR_ENABLE) enable <= cfg_wdata[TOT-1:0];
  end

  // Eligibility is built from registered state only
  assign eligible = pending & enable;

  intc_prio_enc #(
    .W (TOT)
  ) u_prio (
    .req (eligible),
    .vld (win_vld),
    .idx (win_id)
  );

  // Handshake FSM with registered interrupt and id outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      interrupt <= 1'b0;
      irq_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            state     <= REQ;
            interrupt <= 1'b1;
            irq_id    <= win_id;
          end
        end
        REQ: begin
          // A taken trap outranks a late mask change
          if (irq_ack) begin
            state     <= SERVICE;
            interrupt <= 1'b0;
          end else if (!id_en) begin
            state     <= IDLE;
            interrupt <= 1'b0;
          end
        end
        SERVICE: begin
          if (irq_done) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          interrupt <= 1'b0;
        end
      endcase
    end
  end

  // Register read mux
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_ENABLE:  cfg_rdata = 32'(enable);
      ADDR_PENDING: cfg_rdata = 32'(pending);
`ifdef INTC_TIMER_EN
      ADDR_TCMP:    cfg_rdata = tcmp;
      ADDR_TCNT:    cfg_rdata = tcnt;
`endif
      default:      cfg_rdata = '0;
    endcase
  end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 NUM_SRC, 8, number of external interrupt sources, legal 2..31.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 src  input  NUM_SRC  external interrupt request lines, synchronous to clk.
REQ-005 cfg_we  input  1  configuration write strobe.
REQ-006 cfg_addr  input  2  register select: 0 enable, 1 pending, 2 timer compare, 3 timer count.
REQ-007 cfg_wdata  input  32  write data.
REQ-008 cfg_rdata  output  32  combinational read data for cfg_addr.
REQ-009 interrupt  output  1  request to core; held high until acknowledged.
REQ-010 irq_id  output  5  id of the request being presented or serviced.
REQ-011 irq_ack  input  1  core took the trap; one-cycle pulse.
REQ-012 irq_done  input  1  core executed mret; one-cycle pulse.

Function
REQ-013 A rising edge on src[i] (0 last cycle, 1 now) SHALL set pending[i] in the following cycle.
REQ-014 The request SHALL be eligible when (pending & enable) != 0; the lowest set index wins.
REQ-015 FSM states: IDLE, REQ, SERVICE.
REQ-016 IDLE -> REQ the cycle after an eligible request exists; irq_id latches the winning index on entry and stays stable in REQ and SERVICE.
REQ-017 interrupt SHALL be 1 exactly while in REQ.
REQ-018 REQ with irq_ack=1 -> SERVICE; pending[irq_id] cleared in the same edge.
REQ-019 A new edge on src[irq_id] coinciding with the ack clear SHALL leave pending[irq_id] set (set wins).
REQ-020 SERVICE with irq_done=1 -> IDLE; no nesting, new requests wait in pending.
REQ-021 irq_done outside SERVICE and irq_ack outside REQ SHALL be ignored.
REQ-022 If enable[irq_id] is cleared while in REQ, the FSM SHALL return to IDLE without clearing pending.
REQ-023 Write addr 0: enable <= cfg_wdata[NUM_SRC-1:0]; addr 1: write-1-to-clear pending bits; a clear and a set on the same bit in the same cycle: set wins.
REQ-024 Read addr 0/1 returns enable/pending zero-extended; addr 2/3 returns timer registers, or 0 when the timer is not built.
REQ-025 Eligibility SHALL use the registered pending/enable values, so a config write takes effect the cycle after it.

Reset
REQ-026 On reset: state IDLE, interrupt 0, irq_id 0, pending 0, enable 0, edge-history 0, timer count 0, timer compare 0xFFFF_FFFF.
REQ-027 Reset asserted in REQ or SERVICE SHALL abandon the request with no ack or done required.

Configuration
REQ-028 INTC_TIMER_EN defined: a 32-bit free-running count increments every cycle and wraps 0xFFFF_FFFF -> 0. Match (count == compare) asserts internal source id NUM_SRC through the same edge/pending/enable path, with enable bit NUM_SRC. Addr 2 writes compare; addr 3 writes count, and the write overrides the increment.
REQ-029 INTC_TIMER_EN undefined: no timer logic; only ids 0..NUM_SRC-1 exist; addr 2/3 writes are ignored and reads return 0.

Structure
REQ-030 Shared package intc_pkg holds the FSM state enum, the cfg_addr localparams and the 5-bit id width constant.
REQ-031 Sub-module intc_prio_enc: combinational lowest-index priority encoder with valid flag, parameterized width.

Verification
REQ-032 enable=0x01, pulse src[0] one cycle at cycle 5 -> pending[0]=1 at cycle 6, interrupt=1 at cycle 7 with irq_id=0, held until irq_ack.
REQ-033 enable=0xFF, src[3] and src[5] rise in the same cycle -> irq_id=3 first; after ack and done, irq_id=5 presented, interrupt high again.
REQ-034 Ack for id 2 in the same cycle as a new src[2] edge -> after done, id 2 is requested again.
REQ-035 enable=0x00, src[1] pulses -> interrupt stays 0 and pending reads 0x02; writing addr 1 with 0x02 -> pending reads 0.
REQ-036 Reset asserted while in SERVICE -> interrupt 0, pending 0 and enable 0 next cycle; a later irq_done has no effect.
REQ-037 INTC_TIMER_EN: compare=20, enable bit NUM_SRC set, count=0 -> interrupt with irq_id=NUM_SRC rises 2 cycles after count==20.
